// File: rtl/apb_uart_fifo.sv
// APB3 slave UART with TX/RX FIFOs, a programmable baud divisor, parity and stop-bit
// configuration, sticky error flags and a maskable registered interrupt.
// Ports:
//   PCLK, PRESET            clock, synchronous active-high reset
//   PADDR/PSEL/PENABLE/
//   PWRITE/PWDATA           APB3 request; PADDR[4:2] selects the register
//   PRDATA/PREADY/PSLVERR   APB3 response (no wait states)
//   RX, TX                  serial input (asynchronous) and serial output
//   TXRDY, RXRDY, IRQ       TX FIFO not full, RX FIFO not empty, interrupt
module apb_uart_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned TX_DEPTH   = 16,
  parameter int unsigned RX_DEPTH   = 16,
  parameter logic [15:0] BAUD_RESET = 16'd1
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [4:0]  PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [15:0] PWDATA,
  output logic [15:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        RX,
  output logic        TX,
  output logic        TXRDY,
  output logic        RXRDY,
  output logic        IRQ
);
  localparam int unsigned TAW = $clog2(TX_DEPTH);
  localparam int unsigned RAW = $clog2(RX_DEPTH);
  localparam logic [2:0] LastBit = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} uart_st_e;

  // APB decode
  logic [2:0] reg_sel;
  logic access, bad_addr, wr_en, rd_en;
  assign reg_sel  = PADDR[4:2];
  assign access   = PSEL & PENABLE;
  assign bad_addr = (reg_sel >= 3'd5);
  assign wr_en    = access & PWRITE & ~bad_addr;
  assign rd_en    = access & ~PWRITE & ~bad_addr;
  assign PSLVERR  = access & bad_addr;
  assign PREADY   = 1'b1;

  logic [15:0] baud_q, baud_cnt_q;
  logic [4:0]  ctrl_q;
  logic [3:0]  flags_q, flags_d;  // {TXOVF, OVERFLOW, FRAMING_ERR, PARITY_ERR}
  logic        irq_q, tick;

  // Baud tick generator; a BAUD write restarts the count.
  assign tick = (baud_cnt_q >= baud_q);
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      baud_q     <= BAUD_RESET;
      baud_cnt_q <= '0;
      ctrl_q     <= '0;
    end else begin
      if (wr_en && reg_sel == 3'd2) baud_q <= PWDATA;
      if (wr_en && reg_sel == 3'd3) ctrl_q <= PWDATA[4:0];
      if ((wr_en && reg_sel == 3'd2) || tick) baud_cnt_q <= '0;
      else                                    baud_cnt_q <= baud_cnt_q + 16'd1;
    end
  end

  // TX FIFO
  logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
  logic [TAW:0] tx_wp_q, tx_rp_q;
  logic tx_empty, tx_full, tx_pop, tx_push, tx_push_req, txovf_set;
  uart_st_e tx_st_q, tx_st_d;
  assign tx_empty    = (tx_wp_q == tx_rp_q);
  assign tx_full     = (tx_wp_q[TAW] != tx_rp_q[TAW]) && (tx_wp_q[TAW-1:0] == tx_rp_q[TAW-1:0]);
  assign tx_pop      = (tx_st_q == StIdle) & tick & ~tx_empty;
  assign tx_push_req = wr_en && (reg_sel == 3'd0);
  // A pop in the same cycle frees the slot, so a push to a full FIFO is still taken.
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);
  assign txovf_set   = tx_push_req & tx_full & ~tx_pop;

  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem[tx_wp_q[TAW-1:0]] <= PWDATA[DATA_BITS-1:0];
  end

  // TX shifter
  logic [4:0] tx_cnt_q, tx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  always_comb begin
    tx_st_d   = tx_st_q;
    tx_cnt_d  = tx_cnt_q;
    tx_bit_d  = tx_bit_q;
    tx_data_d = tx_data_q;
    TX        = 1'b1;
    case (tx_st_q)
      StIdle: begin
        if (tx_pop) begin
          tx_st_d   = StStart;
          tx_cnt_d  = '0;
          tx_data_d = tx_mem[tx_rp_q[TAW-1:0]];
        end
      end
      StStart: begin
        TX = 1'b0;
        if (tick) begin
          tx_cnt_d = tx_cnt_q + 5'd1;
          if (tx_cnt_q == 5'd15) begin
            tx_st_d  = StData;
            tx_cnt_d = '0;
            tx_bit_d = '0;
          end
        end
      end
      StData: begin
        TX = tx_data_q[tx_bit_q];
        if (tick) begin
          tx_cnt_d = tx_cnt_q + 5'd1;
          if (tx_cnt_q == 5'd15) begin
            tx_cnt_d = '0;
            tx_bit_d = tx_bit_q + 3'd1;
            if (tx_bit_q == LastBit) tx_st_d = ctrl_q[0] ? StParity : StStop;
          end
        end
      end
      StParity: begin
        TX = (^tx_data_q) ^ ctrl_q[1];
        if (tick) begin
          tx_cnt_d = tx_cnt_q + 5'd1;
          if (tx_cnt_q == 5'd15) begin
            tx_st_d  = StStop;
            tx_cnt_d = '0;
          end
        end
      end
      StStop: begin
        if (tick) begin
          tx_cnt_d = tx_cnt_q + 5'd1;
          if (tx_cnt_q == (ctrl_q[2] ? 5'd31 : 5'd15)) begin
            tx_st_d  = StIdle;
            tx_cnt_d = '0;
          end
        end
      end
      default: tx_st_d = StIdle;
    endcase
  end

  // RX FIFO and receiver
  logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
  logic [RAW:0] rx_wp_q, rx_rp_q;
  logic rx_empty, rx_full, rx_pop, rx_push, rx_push_req, ovf_set, par_set, frm_set;
  logic rx_meta_q, rx_sync_q, rx_prev_q, rx_mid, rx_end;
  uart_st_e rx_st_q, rx_st_d;
  logic [3:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, rx_head;
  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = (rx_wp_q[RAW] != rx_rp_q[RAW]) && (rx_wp_q[RAW-1:0] == rx_rp_q[RAW-1:0]);
  assign rx_head  = rx_mem[rx_rp_q[RAW-1:0]];
  assign rx_pop   = rd_en && (reg_sel == 3'd1) && !rx_empty;
  assign rx_push  = rx_push_req & (~rx_full | rx_pop);
  assign ovf_set  = rx_push_req & rx_full & ~rx_pop;
  assign rx_mid   = tick && (rx_cnt_q == 4'd8);
  assign rx_end   = tick && (rx_cnt_q == 4'd15);

  always_ff @(posedge PCLK) begin
    if (rx_push) rx_mem[rx_wp_q[RAW-1:0]] <= rx_shift_q;
  end

  always_comb begin
    rx_st_d     = rx_st_q;
    rx_cnt_d    = tick ? rx_cnt_q + 4'd1 : rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_push_req = 1'b0;
    par_set     = 1'b0;
    frm_set     = 1'b0;
    case (rx_st_q)
      StIdle: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_st_d = StStart;
      end
      StStart: begin
        if (rx_mid && rx_sync_q) rx_st_d = StIdle;  // glitch, not a start bit
        else if (rx_end) begin
          rx_st_d  = StData;
          rx_bit_d = '0;
        end
      end
      StData: begin
        if (rx_mid) rx_shift_d[rx_bit_q] = rx_sync_q;
        if (rx_end) begin
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == LastBit) rx_st_d = ctrl_q[0] ? StParity : StStop;
        end
      end
      StParity: begin
        if (rx_mid) par_set = (rx_sync_q != ((^rx_shift_q) ^ ctrl_q[1]));
        if (rx_end) rx_st_d = StStop;
      end
      StStop: begin
        if (rx_mid) begin
          rx_push_req = 1'b1;
          frm_set     = ~rx_sync_q;
          rx_st_d     = StIdle;
        end
      end
      default: rx_st_d = StIdle;
    endcase
  end

  // Sticky flags: a set event in the same cycle as a W1C wins.
  always_comb begin
    flags_d = flags_q;
    if (wr_en && reg_sel == 3'd4) flags_d = flags_q & ~PWDATA[7:4];
    flags_d = flags_d | {txovf_set, ovf_set, frm_set, par_set};
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      tx_st_q    <= StIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_data_q  <= '0;
      rx_st_q    <= StIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      flags_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
      tx_st_q    <= tx_st_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_data_q  <= tx_data_d;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_meta_q  <= RX;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      flags_q    <= flags_d;
      irq_q      <= (ctrl_q[3] & tx_empty) |
                    (ctrl_q[4] & (~rx_empty | flags_q[0] | flags_q[1] | flags_q[2]));
    end
  end

  always_comb begin
    PRDATA = '0;
    if (rd_en) begin
      case (reg_sel)
        3'd1:    PRDATA = rx_empty ? 16'd0 : {{(16 - DATA_BITS){1'b0}}, rx_head};
        3'd2:    PRDATA = baud_q;
        3'd3:    PRDATA = {11'd0, ctrl_q};
        3'd4:    PRDATA = {8'd0, flags_q, rx_full, ~rx_empty, tx_full, tx_empty};
        default: PRDATA = '0;
      endcase
    end
  end

  assign TXRDY = ~tx_full;
  assign RXRDY = ~rx_empty;
  assign IRQ   = irq_q;
endmodule

// File: tb/tb_apb_uart_fifo.sv
module tb_apb_uart_fifo;
  localparam int TXD = 4;
  localparam int RXD = 4;

  logic        PCLK = 1'b0, PRESET = 1'b1;
  logic [4:0]  PADDR = '0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [15:0] PWDATA = '0;
  logic [15:0] PRDATA;
  logic        PREADY, PSLVERR, TX, TXRDY, RXRDY, IRQ;
  logic        rx_drv = 1'b1, loopback = 1'b0, rx_line;
  assign rx_line = loopback ? TX : rx_drv;

  apb_uart_fifo #(.DATA_BITS(8), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .BAUD_RESET(16'd1)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .RX(rx_line), .TX(TX), .TXRDY(TXRDY), .RXRDY(RXRDY), .IRQ(IRQ)
  );

  always #5 PCLK = ~PCLK;

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic apb(input logic w, input logic [4:0] a, input logic [15:0] wd,
                     output logic [15:0] rd, output logic er);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = wd;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2;
    rd = PRDATA; er = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    logic [15:0] r; logic e;
    apb(1'b1, a, d, r, e);
  endtask

  task automatic rd(input logic [4:0] a, output logic [15:0] d);
    logic e;
    apb(1'b0, a, 16'd0, d, e);
  endtask

  task automatic wait_rx(input string name, input int budget);
    int n = 0;
    while (!RXRDY && n < budget) begin @(negedge PCLK); n++; end
    check(name, RXRDY, 1);
  endtask

  // Serialises one character onto rx_drv at 16 PCLK per bit (BAUD must be 0).
  task automatic send_rx(input logic [7:0] d, input logic pe, input logic po,
                         input logic pflip, input logic stop_bad);
    @(posedge PCLK); #1;
    rx_drv = 1'b0; repeat (16) @(posedge PCLK); #1;
    for (int i = 0; i < 8; i++) begin rx_drv = d[i]; repeat (16) @(posedge PCLK); #1; end
    if (pe) begin rx_drv = (^d) ^ po ^ pflip; repeat (16) @(posedge PCLK); #1; end
    rx_drv = ~stop_bad; repeat (16) @(posedge PCLK); #1;
    rx_drv = 1'b1; repeat (24) @(posedge PCLK); #1;
  endtask

  typedef struct {
    string       name;
    logic        w;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];
  logic [15:0] r, st;
  logic e;
  logic [7:0] d, exp_q[$], tx_bytes[TXD+2];
  logic pe, po, pf, sb;
  int n;

  initial begin
    vecs[0]  = '{"status_rst", 1'b0, 5'h10, 16'h0000, 16'h0001, 1'b0};
    vecs[1]  = '{"ctrl_rst",   1'b0, 5'h0C, 16'h0000, 16'h0000, 1'b0};
    vecs[2]  = '{"baud_rst",   1'b0, 5'h08, 16'h0000, 16'h0001, 1'b0};
    vecs[3]  = '{"baud_wr",    1'b1, 5'h08, 16'h1234, 16'h0000, 1'b0};
    vecs[4]  = '{"baud_rd",    1'b0, 5'h08, 16'h0000, 16'h1234, 1'b0};
    vecs[5]  = '{"ctrl_wr",    1'b1, 5'h0C, 16'hFFFF, 16'h0000, 1'b0};
    vecs[6]  = '{"ctrl_rd",    1'b0, 5'h0C, 16'h0000, 16'h001F, 1'b0};
    vecs[7]  = '{"err_rd14",   1'b0, 5'h14, 16'h0000, 16'h0000, 1'b1};
    vecs[8]  = '{"err_wr18",   1'b1, 5'h18, 16'hFFFF, 16'h0000, 1'b1};
    vecs[9]  = '{"err_rd1c",   1'b0, 5'h1C, 16'h0000, 16'h0000, 1'b1};
    vecs[10] = '{"rx_empty",   1'b0, 5'h04, 16'h0000, 16'h0000, 1'b0};
    vecs[11] = '{"txdata_rd",  1'b0, 5'h00, 16'h0000, 16'h0000, 1'b0};
    vecs[12] = '{"ctrl_clr",   1'b1, 5'h0C, 16'h0000, 16'h0000, 1'b0};
    vecs[13] = '{"ctrl_rd0",   1'b0, 5'h0C, 16'h0000, 16'h0000, 1'b0};
    vecs[14] = '{"status_w1c", 1'b1, 5'h10, 16'hFFFF, 16'h0000, 1'b0};
    vecs[15] = '{"status_rd",  1'b0, 5'h10, 16'h0000, 16'h0001, 1'b0};

    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    check("rst_tx", TX, 1);
    check("rst_txrdy", TXRDY, 1);
    check("rst_rxrdy", RXRDY, 0);
    check("rst_irq", IRQ, 0);
    check("rst_prdata", PRDATA, 0);
    check("rst_pslverr", PSLVERR, 0);
    check("rst_pready", PREADY, 1);

    foreach (vecs[i]) begin
      apb(vecs[i].w, vecs[i].addr, vecs[i].wdata, r, e);
      check({vecs[i].name, "_err"}, e, vecs[i].exp_err);
      if (!vecs[i].w) check(vecs[i].name, r, vecs[i].exp_rd);
    end

    // T1: exact TX waveform for 0xA5 at BAUD=0
    wr(5'h08, 16'd0);
    wr(5'h0C, 16'd0);
    wr(5'h00, 16'h00A5);
    n = 0;
    while (TX && n < 50) begin @(negedge PCLK); n++; end
    check("t1_start_seen", TX, 0);
    n = 0;
    while (!TX && n < 40) begin @(negedge PCLK); n++; end
    check("t1_start_len", n, 16);
    d = 8'hA5;
    repeat (8) @(negedge PCLK);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) repeat (16) @(negedge PCLK);
      check($sformatf("t1_bit%0d", i), TX, d[i]);
    end
    repeat (16) @(negedge PCLK);
    check("t1_stop", TX, 1);
    repeat (20) @(negedge PCLK);
    rd(5'h10, st);
    check("t1_status", st, 16'h0001);

    // T2: loopback with odd parity
    loopback = 1'b1;
    wr(5'h0C, 16'h0003);
    wr(5'h00, 16'h003C);
    wait_rx("t2_wait", 400);
    rd(5'h04, r);
    check("t2_data", r, 16'h003C);
    check("t2_rxrdy_after", RXRDY, 0);
    rd(5'h10, st);
    check("t2_parity_err", st[4], 0);

    // Random loopback: random framing config and baud, data must round-trip cleanly
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom);
      st = 16'($urandom_range(0, 7));
      wr(5'h08, 16'($urandom_range(0, 3)));
      wr(5'h0C, st);
      wr(5'h00, {8'd0, d});
      wait_rx("rl_wait", 1200);
      rd(5'h04, r);
      check("rl_data", r, {8'd0, d});
      rd(5'h10, st);
      check("rl_flags", st[7:4], 0);
      repeat (150) @(negedge PCLK);  // let the second stop bit drain
    end

    // T3: fill the TX FIFO while the shifter is busy
    wr(5'h0C, 16'd0);
    wr(5'h08, 16'd3);
    for (int i = 0; i < TXD + 2; i++) tx_bytes[i] = 8'($urandom);
    wr(5'h00, {8'd0, tx_bytes[0]});
    n = 0;
    st = 16'd0;
    while (!st[0] && n < 20) begin rd(5'h10, st); n++; end
    check("t3_shifter_took", st[0], 1);
    for (int i = 1; i < TXD + 2; i++) wr(5'h00, {8'd0, tx_bytes[i]});
    @(negedge PCLK);
    check("t3_txrdy", TXRDY, 0);
    rd(5'h10, st);
    check("t3_txfull", st[1], 1);
    check("t3_txovf", st[7], 1);
    wr(5'h10, 16'h0080);
    rd(5'h10, st);
    check("t3_txovf_clr", st[7], 0);
    for (int i = 0; i < TXD + 1; i++) begin
      wait_rx("t3_wait", 1500);
      rd(5'h04, r);
      check($sformatf("t3_byte%0d", i), r, {8'd0, tx_bytes[i]});
    end
    repeat (900) @(negedge PCLK);
    check("t3_no_extra", RXRDY, 0);
    loopback = 1'b0;

    // T4: RX overflow, FIFO order preserved
    wr(5'h08, 16'd0);
    exp_q.delete();
    for (int i = 0; i < RXD + 1; i++) begin
      d = 8'($urandom);
      if (i < RXD) exp_q.push_back(d);
      send_rx(d, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rd(5'h10, st);
    check("t4_overflow", st[6], 1);
    check("t4_rxfull", st[3], 1);
    for (int i = 0; i < RXD; i++) begin
      rd(5'h04, r);
      check($sformatf("t4_byte%0d", i), r, {8'd0, exp_q.pop_front()});
    end
    rd(5'h04, r);
    check("t4_empty_read", r, 0);
    wr(5'h10, 16'h0040);

    // Random RX: injected parity/framing errors against the spec rules
    for (int k = 0; k < 12; k++) begin
      d = 8'($urandom);
      pe = 1'($urandom); po = 1'($urandom);
      pf = ($urandom_range(0, 3) == 0); sb = ($urandom_range(0, 3) == 0);
      wr(5'h0C, {14'd0, po, pe});
      send_rx(d, pe, po, pf, sb);
      wait_rx("rr_wait", 50);
      rd(5'h04, r);
      check("rr_data", r, {8'd0, d});
      rd(5'h10, st);
      check("rr_flags", st[6:4], {1'b0, sb, pe & pf});
      wr(5'h10, 16'h0070);
    end

    // T5: framing error with RXIE, then a short glitch
    wr(5'h0C, 16'h0010);
    repeat (2) @(negedge PCLK);
    check("t5_irq_idle", IRQ, 0);
    send_rx(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    rd(5'h10, st);
    check("t5_framing", st[5], 1);
    check("t5_irq", IRQ, 1);
    rd(5'h04, r);
    check("t5_data", r, 16'h005A);
    wr(5'h10, 16'h0020);
    repeat (2) @(negedge PCLK);
    check("t5_irq_clr", IRQ, 0);
    @(posedge PCLK); #1 rx_drv = 1'b0;
    repeat (8) @(posedge PCLK);
    #1 rx_drv = 1'b1;
    repeat (300) @(negedge PCLK);
    check("t5_glitch_rxrdy", RXRDY, 0);
    rd(5'h10, st);
    check("t5_glitch_status", st, 16'h0001);
    wr(5'h0C, 16'h0008);
    @(posedge PCLK); @(negedge PCLK);
    check("txie_irq", IRQ, 1);
    wr(5'h0C, 16'h0000);

    // T6: reset pulse in the middle of a character
    wr(5'h00, 16'h0000);
    n = 0;
    while (TX && n < 50) begin @(negedge PCLK); n++; end
    repeat (40) @(negedge PCLK);
    check("t6_tx_mid", TX, 0);
    @(posedge PCLK); #1 PRESET = 1'b1;
    @(posedge PCLK); #1 PRESET = 1'b0;
    check("t6_tx_after", TX, 1);
    rd(5'h10, st);
    check("t6_status", st, 16'h0001);
    rd(5'h08, r);
    check("t6_baud", r, 16'h0001);
    repeat (400) @(negedge PCLK);
    check("t6_tx_idle", TX, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
